// File: rtl/sdram_responder_if.sv
// Command, address and byte-mask pins between an SDR SDRAM controller and the device.
interface sdram_responder_if;
   logic        dram_cke;
   logic        dram_cs_n;
   logic        dram_ras_n;
   logic        dram_cas_n;
   logic        dram_we_n;
   logic [1:0]  dram_ba;
   logic [12:0] dram_addr;
   logic        dram_ldqm;
   logic        dram_udqm;

   modport master (
      output dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
      output dram_ba, dram_addr, dram_ldqm, dram_udqm
   );
   modport slave (
      input dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
      input dram_ba, dram_addr, dram_ldqm, dram_udqm
   );
endinterface

// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: decodes controller commands, tracks open rows and serves
// CAS-latency read bursts and byte-masked write bursts from an on-chip array.
module sdram_responder #(
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int COL_BITS       = 10
) (
   input  logic             clk,
   input  logic             rst,
   sdram_responder_if.slave bus,
   inout  wire  [15:0]      dram_dq,
   output logic             mode_valid,
   output logic             cmd_err,
   output logic [15:0]      ref_count,
   output logic [3:0]       open_banks
);
   localparam int IDX_W = 15 + COL_BITS;
   localparam logic [2:0] CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010,
                          CMD_ACT = 3'b011, CMD_WR  = 3'b100, CMD_RD  = 3'b101,
                          CMD_BST = 3'b110;

   typedef logic [COL_BITS-1:0]       col_t;
   typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;

   logic [15:0] mem [2**MEM_ADDR_WIDTH];
   logic [12:0] open_row [4];

   logic        cl3;
   logic [2:0]  bl_code;
   logic        single_wr;

   logic        g_active, g_wr, g_page, g_ap;
   logic [2:0]  g_cnt;
   logic [1:0]  g_ba;
   logic [12:0] g_row;
   col_t        g_col;

   logic        vld_p0, vld_p1, vld_p2;
   idx_t        addr_p0, addr_p1;
   logic [15:0] dq_p2;

   logic [2:0]  cmd, new_len_m1;
   logic        bank_open, err_n, pre_go, ref_go, mrs_go, act_go, rd_go, wr_go, bst_go;
   logic        kill, gen_beat, g_last, new_single, new_page, new_one;
   logic        wr_fire, rd_fire, src_vld;
   col_t        col_mask;
   idx_t        cmd_idx, gen_idx, wr_idx, rd_idx, src_idx;
   logic [15:0] wr_word, rd_word;
   logic [3:0]  banks_n;

   // Burst block mask; a full-page burst wraps over the whole row.
   function automatic col_t bl_mask(input logic [2:0] code);
      case (code)
         3'b000:  return col_t'(0);
         3'b001:  return col_t'(1);
         3'b010:  return col_t'(3);
         3'b011:  return col_t'(7);
         default: return '1;
      endcase
   endfunction

   function automatic col_t next_col(input col_t col, input col_t mask);
      return (col & ~mask) | ((col + col_t'(1)) & mask);
   endfunction

   function automatic idx_t mem_idx(input logic [1:0] ba, input logic [12:0] row, input col_t col);
      logic [IDX_W-1:0] full;
      full = {ba, row, col};
      return full[MEM_ADDR_WIDTH-1:0];
   endfunction

   always_comb begin
      cmd       = {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
      bank_open = open_banks[bus.dram_ba];
      col_mask  = bl_mask(bl_code);
      err_n     = 1'b0;
      pre_go    = 1'b0;
      ref_go    = 1'b0;
      mrs_go    = 1'b0;
      act_go    = 1'b0;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      bst_go    = 1'b0;
      if (!bus.dram_cs_n && bus.dram_cke) begin
         case (cmd)
            CMD_PRE: pre_go = 1'b1;
            CMD_REF: if (open_banks == 4'd0) ref_go = 1'b1; else err_n = 1'b1;
            CMD_MRS: if ((bus.dram_addr[6:4] == 3'd2 || bus.dram_addr[6:4] == 3'd3) &&
                         (!bus.dram_addr[2] || bus.dram_addr[2:0] == 3'b111)) mrs_go = 1'b1;
                     else err_n = 1'b1;
            CMD_ACT: if (!mode_valid || bank_open) err_n = 1'b1; else act_go = 1'b1;
            CMD_RD:  if (!mode_valid || !bank_open) err_n = 1'b1; else rd_go = 1'b1;
            CMD_WR:  if (!mode_valid || !bank_open) err_n = 1'b1; else wr_go = 1'b1;
            CMD_BST: if (!mode_valid) err_n = 1'b1; else bst_go = 1'b1;
            default: ;
         endcase
      end
      kill       = bst_go || rd_go || wr_go ||
                   (pre_go && (bus.dram_addr[10] || bus.dram_ba == g_ba));
      gen_beat   = g_active && !kill;
      g_last     = gen_beat && !g_page && g_cnt == 3'd1;
      new_single = wr_go && single_wr;
      new_page   = !new_single && bl_code == 3'b111;
      new_len_m1 = new_single ? 3'd0 : col_mask[2:0];
      new_one    = !new_page && new_len_m1 == 3'd0;
      cmd_idx    = mem_idx(bus.dram_ba, open_row[bus.dram_ba], bus.dram_addr[COL_BITS-1:0]);
      gen_idx    = mem_idx(g_ba, g_row, g_col);
      wr_fire    = wr_go || (gen_beat && g_wr);
      wr_idx     = wr_go ? cmd_idx : gen_idx;
      rd_fire    = rd_go || (gen_beat && !g_wr);
      rd_idx     = rd_go ? cmd_idx : gen_idx;
      wr_word    = mem[wr_idx];
      if (!bus.dram_udqm) wr_word[15:8] = dram_dq[15:8];
      if (!bus.dram_ldqm) wr_word[7:0]  = dram_dq[7:0];
      src_vld    = cl3 ? vld_p1 : vld_p0;
      src_idx    = cl3 ? addr_p1 : addr_p0;
      rd_word    = (wr_fire && wr_idx == src_idx) ? wr_word : mem[src_idx];
      banks_n    = open_banks;
      if (g_last && g_ap) banks_n[g_ba] = 1'b0;
      if ((rd_go || wr_go) && new_one && bus.dram_addr[10]) banks_n[bus.dram_ba] = 1'b0;
      if (act_go) banks_n[bus.dram_ba] = 1'b1;
      if (pre_go) begin
         if (bus.dram_addr[10]) banks_n = 4'd0;
         else                   banks_n[bus.dram_ba] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_valid <= 1'b0;
         cmd_err    <= 1'b0;
         ref_count  <= 16'd0;
         open_banks <= 4'd0;
         cl3        <= 1'b0;
         bl_code    <= 3'd0;
         single_wr  <= 1'b0;
         g_active   <= 1'b0;
         g_wr       <= 1'b0;
         g_page     <= 1'b0;
         g_ap       <= 1'b0;
         g_cnt      <= 3'd0;
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
      end else begin
         cmd_err    <= err_n;
         open_banks <= banks_n;
         if (ref_go) ref_count <= ref_count + 16'd1;
         if (mrs_go) begin
            mode_valid <= 1'b1;
            cl3        <= bus.dram_addr[4];
            bl_code    <= bus.dram_addr[2:0];
            single_wr  <= bus.dram_addr[9];
         end
         if (rd_go || wr_go) begin
            g_active <= !new_one;
            g_wr     <= wr_go;
            g_page   <= new_page;
            g_ap     <= bus.dram_addr[10];
            g_cnt    <= new_len_m1;
         end else if (kill || g_last) begin
            g_active <= 1'b0;
         end else if (gen_beat && !g_page) begin
            g_cnt    <= g_cnt - 3'd1;
         end
         // p0: beat issued; p1: extra CL=3 delay; p2: word on dq. A WRITE flushes all.
         vld_p0 <= rd_fire;
         vld_p1 <= vld_p0 && !wr_go;
         vld_p2 <= src_vld && !wr_go;
      end
   end

   always_ff @(posedge clk) begin
      if (act_go) open_row[bus.dram_ba] <= bus.dram_addr;
      if (rd_go || wr_go) begin
         g_ba  <= bus.dram_ba;
         g_row <= open_row[bus.dram_ba];
         g_col <= next_col(bus.dram_addr[COL_BITS-1:0], col_mask);
      end else if (gen_beat) begin
         g_col <= next_col(g_col, col_mask);
      end
      addr_p0 <= rd_idx;
      addr_p1 <= addr_p0;
      dq_p2   <= rd_word;
      if (wr_fire) mem[wr_idx] <= wr_word;
   end

   assign dram_dq = vld_p2 ? dq_p2 : 16'hzzzz;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: command legality, CL/BL read timing, byte masks,
// burst terminate, auto-precharge and asynchronous reset. Released dq reads as 16'hFFFF.
module tb_sdram_responder;
   localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                          C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;
   localparam logic [15:0] DQ_Z = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tb_dq_en = 1'b0;
   logic [15:0] tb_dq = 16'h0;
   wire  [15:0] dram_dq;
   logic        mode_valid, cmd_err;
   logic [15:0] ref_count;
   logic [3:0]  open_banks;
   logic [15:0] exp4 [4];
   logic [15:0] exp_sw [4];
   int          n_tests = 0;
   int          n_fail = 0;

   sdram_responder_if bus ();

   sdram_responder dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .dram_dq    (dram_dq),
      .mode_valid (mode_valid),
      .cmd_err    (cmd_err),
      .ref_count  (ref_count),
      .open_banks (open_banks)
   );

   assign dram_dq = tb_dq_en ? tb_dq : 16'hzzzz;
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup pu (dram_dq[i]);
   end

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; the command is sampled at the next rising edge.
   task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic den = 1'b0, input logic [15:0] d = 16'h0,
                        input logic [1:0] dqm = 2'b00);
      {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = c;
      bus.dram_ba   = ba;
      bus.dram_addr = a;
      {bus.dram_udqm, bus.dram_ldqm} = dqm;
      tb_dq_en = den;
      tb_dq    = d;
      @(negedge clk);
      {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = C_NOP;
      {bus.dram_udqm, bus.dram_ldqm} = 2'b00;
      tb_dq_en = 1'b0;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp4   = '{16'd3, 16'd4, 16'd1, 16'd2};
      exp_sw = '{16'h5555, 16'hA009, 16'hA00A, 16'hA00B};
      bus.dram_cke = 1'b1;
      bus.dram_cs_n = 1'b0;
      {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = C_NOP;
      bus.dram_ba = 2'd0;
      bus.dram_addr = 13'd0;
      {bus.dram_udqm, bus.dram_ldqm} = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_mode",  32'(mode_valid), 32'd0);
      chk("rst_ref",   32'(ref_count),  32'd0);
      chk("rst_banks", 32'(open_banks), 32'd0);
      chk("rst_err",   32'(cmd_err),    32'd0);
      chk("rst_dq",    32'(dram_dq),    32'(DQ_Z));
      rst = 1'b1;
      @(negedge clk);

      // Init sequence, with an ACT rejected before the mode register is set
      issue(C_PRE, 2'd0, 13'h400);
      chk("pre_all_err", 32'(cmd_err), 32'd0);
      issue(C_ACT, 2'd0, 13'd5);
      chk("act_nomode_err",   32'(cmd_err),    32'd1);
      chk("act_nomode_banks", 32'(open_banks), 32'd0);
      repeat (8) issue(C_REF, 2'd0, 13'd0);
      chk("ref8",     32'(ref_count), 32'd8);
      chk("ref8_err", 32'(cmd_err),   32'd0);
      issue(C_MRS, 2'd0, 13'h027);
      chk("mrs_valid", 32'(mode_valid), 32'd1);
      chk("mrs_err",   32'(cmd_err),    32'd0);

      // Single word CL=2, then byte-masked write and CL=3 read
      issue(C_MRS, 2'd0, 13'h020);
      issue(C_ACT, 2'd0, 13'd5);
      chk("act_banks", 32'(open_banks), 32'h1);
      issue(C_WR, 2'd0, 13'd3, 1'b1, 16'hBEEF);
      issue(C_RD, 2'd0, 13'd3);
      chk("cl2_n0", 32'(dram_dq), 32'(DQ_Z));
      nop(1); chk("cl2_n1", 32'(dram_dq), 32'hBEEF);
      nop(1); chk("cl2_n2", 32'(dram_dq), 32'(DQ_Z));
      issue(C_WR, 2'd0, 13'd3, 1'b1, 16'h1234, 2'b01);
      issue(C_MRS, 2'd0, 13'h030);
      issue(C_RD, 2'd0, 13'd3);
      nop(1); chk("cl3_n1",   32'(dram_dq), 32'(DQ_Z));
      nop(1); chk("cl3_mask", 32'(dram_dq), 32'h12EF);
      nop(1); chk("cl3_n3",   32'(dram_dq), 32'(DQ_Z));

      // BL=4 write burst, rejected MRS, wrapped read from col 2
      issue(C_MRS, 2'd0, 13'h022);
      issue(C_WR, 2'd0, 13'd0, 1'b1, 16'd1);
      for (int k = 2; k <= 4; k++) issue(C_NOP, 2'd0, 13'd0, 1'b1, 16'(k));
      issue(C_MRS, 2'd0, 13'h012);
      chk("mrs_bad_err",   32'(cmd_err),    32'd1);
      chk("mrs_bad_valid", 32'(mode_valid), 32'd1);
      issue(C_RD, 2'd0, 13'd2);
      for (int k = 0; k < 4; k++) begin
         nop(1); chk("bl4_wrap", 32'(dram_dq), 32'(exp4[k]));
      end
      nop(1); chk("bl4_end", 32'(dram_dq), 32'(DQ_Z));

      // Page write of 40 words, page read cut by BST after 34 words
      issue(C_MRS, 2'd0, 13'h027);
      issue(C_WR, 2'd0, 13'd0, 1'b1, 16'hA000);
      for (int k = 1; k < 40; k++) issue(C_NOP, 2'd0, 13'd0, 1'b1, 16'hA000 + 16'(k));
      issue(C_BST, 2'd0, 13'd0);
      chk("bst_wr_err", 32'(cmd_err), 32'd0);
      issue(C_RD, 2'd0, 13'd0);
      for (int j = 1; j <= 33; j++) begin
         nop(1); chk("page_rd", 32'(dram_dq), 32'(16'hA000 + 16'(j - 1)));
      end
      issue(C_BST, 2'd0, 13'd0);
      chk("page_last", 32'(dram_dq), 32'hA021);
      nop(1); chk("page_bst_z",  32'(dram_dq), 32'(DQ_Z));
      nop(1); chk("page_bst_z2", 32'(dram_dq), 32'(DQ_Z));

      // Single-location write mode: second beat must not land
      issue(C_MRS, 2'd0, 13'h222);
      issue(C_WR, 2'd0, 13'd8, 1'b1, 16'h5555);
      issue(C_NOP, 2'd0, 13'd0, 1'b1, 16'h6666);
      issue(C_RD, 2'd0, 13'd8);
      for (int k = 0; k < 4; k++) begin
         nop(1); chk("single_wr", 32'(dram_dq), 32'(exp_sw[k]));
      end
      nop(1); chk("single_wr_end", 32'(dram_dq), 32'(DQ_Z));

      // Illegal commands while bank 0 is open
      issue(C_RD, 2'd1, 13'd0);
      chk("rd_closed_err", 32'(cmd_err), 32'd1);
      nop(1); chk("err_pulse", 32'(cmd_err), 32'd0);
      issue(C_ACT, 2'd0, 13'd9);
      chk("act_open_err", 32'(cmd_err), 32'd1);
      issue(C_REF, 2'd0, 13'd0);
      chk("ref_open_err", 32'(cmd_err),   32'd1);
      chk("ref_open_cnt", 32'(ref_count), 32'd8);
      issue(C_PRE, 2'd0, 13'd0);
      chk("pre_b0", 32'(open_banks), 32'd0);
      issue(C_REF, 2'd0, 13'd0);
      chk("ref9", 32'(ref_count), 32'd9);

      // Auto-precharge closes bank 2 when the BL=4 read burst ends
      issue(C_MRS, 2'd0, 13'h022);
      issue(C_ACT, 2'd2, 13'd7);
      chk("act_b2", 32'(open_banks), 32'h4);
      issue(C_RD, 2'd2, 13'h400);
      chk("ap_hold", 32'(open_banks), 32'h4);
      nop(2); chk("ap_hold2", 32'(open_banks), 32'h4);
      nop(1); chk("ap_close", 32'(open_banks), 32'h0);
      nop(2);

      // Asynchronous reset in the middle of a page read
      issue(C_MRS, 2'd0, 13'h027);
      issue(C_ACT, 2'd0, 13'd5);
      issue(C_RD, 2'd0, 13'd0);
      nop(2); chk("pre_rst_dq", 32'(dram_dq), 32'hA001);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_dq",    32'(dram_dq),    32'(DQ_Z));
      chk("rst_mid_banks", 32'(open_banks), 32'd0);
      chk("rst_mid_mode",  32'(mode_valid), 32'd0);
      chk("rst_mid_ref",   32'(ref_count),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      issue(C_RD, 2'd0, 13'd0);
      chk("rd_nomode_err", 32'(cmd_err), 32'd1);
      issue(C_MRS, 2'd0, 13'h020);
      issue(C_ACT, 2'd0, 13'd5);
      issue(C_RD, 2'd0, 13'd5);
      nop(1); chk("retained", 32'(dram_dq), 32'hA005);
      nop(1); chk("retained_z", 32'(dram_dq), 32'(DQ_Z));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
